// File: rtl/drs_event_builder.sv
// Frames each completed DRS event from the readout data FIFO into a packet
// (header, payload, trailer) and streams it out over a valid/ready byte port.
module drs_event_builder #(
    parameter logic [15:0] HDR_MAGIC = 16'h5A5A,
    parameter logic [15:0] TRL_MAGIC = 16'hA5A5,
    parameter int          PEND_W    = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EVT_DONE,
    input  logic [12:0] DRS_READDEPTH,
    output logic        DFIFO_RD_EN,
    input  logic [7:0]  DFIFO_DOUT,
    input  logic        DFIFO_EMPTY,
    input  logic        DFIFO_VALID,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic [31:0] EVT_COUNT,
    output logic        BUSY,
    output logic        PEND_OVF
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;
    localparam logic [1:0] S_TRL  = 2'd3;

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [1:0]        state;
    logic [2:0]        evt_sync;
    logic              evt_edge;
    logic [PEND_W-1:0] pending;
    logic              pend_ovf;
    logic [31:0]       evt_count;
    logic [15:0]       pay_len;
    logic [15:0]       byte_idx;
    logic [15:0]       reads_issued;
    logic              rd_inflight;

    logic [7:0]        skid_mem [2];
    logic              skid_wr_ptr;
    logic              skid_rd_ptr;
    logic [1:0]        skid_cnt;
    logic [2:0]        skid_load;

    logic              tx_valid;
    logic [7:0]        tx_data;
    logic [7:0]        hdr_byte;
    logic              tx_fire;
    logic              rd_en;
    logic              skid_push;
    logic              skid_pop;
    logic              pkt_done;

    // evt_sync[1:0] is the synchroniser, evt_sync[2] the history for edge detect.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            evt_sync <= 3'b000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values, regardless of statement order.
            evt_sync <= {evt_sync[1:0], EVT_DONE};
        end
    end

    assign evt_edge = evt_sync[1] & ~evt_sync[2];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        hdr_byte = 8'h00;
        case (byte_idx[2:0])
            3'd0: hdr_byte = HDR_MAGIC[15:8];
            3'd1: hdr_byte = HDR_MAGIC[7:0];
            3'd2: hdr_byte = evt_count[31:24];
            3'd3: hdr_byte = evt_count[23:16];
            3'd4: hdr_byte = evt_count[15:8];
            3'd5: hdr_byte = evt_count[7:0];
            3'd6: hdr_byte = pay_len[15:8];
            3'd7: hdr_byte = pay_len[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte;
            end
            S_PAY: begin
                tx_valid = (skid_cnt != 2'd0);
                tx_data  = (skid_cnt != 2'd0) ? skid_mem[skid_rd_ptr] : 8'h00;
            end
            S_TRL: begin
                tx_valid = 1'b1;
                tx_data  = byte_idx[0] ? TRL_MAGIC[7:0] : TRL_MAGIC[15:8];
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

    assign tx_fire   = tx_valid & TX_READY;
    assign skid_pop  = (state == S_PAY) & tx_fire;
    assign skid_push = DFIFO_VALID & rd_inflight;
    assign skid_load = {1'b0, skid_cnt} + {2'b00, rd_inflight};
    assign pkt_done  = (state == S_TRL) & tx_fire & byte_idx[0];

    // Counting the byte leaving this cycle as free lets reads overlap the pop,
    // which is what sustains one payload byte per cycle.
    assign rd_en = (state == S_PAY) && !DFIFO_EMPTY && (reads_issued < pay_len) &&
                   ((skid_load - {2'b00, skid_pop}) < 3'd2);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            byte_idx  <= 16'd0;
            pay_len   <= 16'd0;
            evt_count <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pending != '0) begin
                        state    <= S_HDR;
                        byte_idx <= 16'd0;
                        pay_len  <= 16'd4 + {1'b0, DRS_READDEPTH, 2'b00};
                    end
                end
                S_HDR: begin
                    if (tx_fire) begin
                        if (byte_idx[2:0] == 3'd7) begin
                            state    <= S_PAY;
                            byte_idx <= 16'd0;
                        end else begin
                            byte_idx <= byte_idx + 16'd1;
                        end
                    end
                end
                S_PAY: begin
                    if (tx_fire) begin
                        if (byte_idx == pay_len - 16'd1) begin
                            state    <= S_TRL;
                            byte_idx <= 16'd0;
                        end else begin
                            byte_idx <= byte_idx + 16'd1;
                        end
                    end
                end
                S_TRL: begin
                    if (tx_fire) begin
                        if (byte_idx[0]) begin
                            state     <= S_IDLE;
                            byte_idx  <= 16'd0;
                            evt_count <= evt_count + 32'd1;
                        end else begin
                            byte_idx <= byte_idx + 16'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pending  <= '0;
            pend_ovf <= 1'b0;
        end else begin
            if (evt_edge && !pkt_done) begin
                if (pending == PEND_MAX) begin
                    pend_ovf <= 1'b1;
                end else begin
                    pending <= pending + 1'b1;
                end
            end else if (pkt_done && !evt_edge) begin
                pending <= pending - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            reads_issued <= 16'd0;
            rd_inflight  <= 1'b0;
            skid_wr_ptr  <= 1'b0;
            skid_rd_ptr  <= 1'b0;
            skid_cnt     <= 2'd0;
        end else begin
            rd_inflight <= rd_en;
            if (state != S_PAY) begin
                reads_issued <= 16'd0;
            end else if (rd_en) begin
                reads_issued <= reads_issued + 16'd1;
            end
            if (skid_push) begin
                skid_wr_ptr <= ~skid_wr_ptr;
            end
            if (skid_pop) begin
                skid_rd_ptr <= ~skid_rd_ptr;
            end
            case ({skid_push, skid_pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    // NOTE: the skid storage has no reset; it is only ever read while skid_cnt
    // says an entry was written, and leaving it out keeps plain RAM-style flops.
    always_ff @(posedge CLK) begin
        if (skid_push) begin
            skid_mem[skid_wr_ptr] <= DFIFO_DOUT;
        end
    end

    assign DFIFO_RD_EN = rd_en;
    assign TX_DATA     = tx_data;
    assign TX_VALID    = tx_valid;
    assign EVT_COUNT   = evt_count;
    assign BUSY        = (state != S_IDLE);
    assign PEND_OVF    = pend_ovf;

endmodule
